effect_frame_ctrl: RTL and testbench

//  Frame-level sequencer for the effect mux path inside the image processor.
//  - Takes effect config from the AXI register bank and drives the mux select line.
//  - Gates the 24-bit pixel stream with valid/ready and counts pixels per frame.
//  - Applies a new effect only at frame boundaries, so no frame mixes effects.
//  - Raises a done pulse when the programmed pixel count has left the block.

---
 rtl/effect_frame_ctrl_pkg.sv | 13 +
 rtl/effect_frame_ctrl_if.sv | 22 ++
 rtl/effect_frame_ctrl_pix_out_reg.sv | 41 ++++
 rtl/effect_frame_ctrl.sv | 140 ++++++++++++++
 tb/tb_effect_frame_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/effect_frame_ctrl_pkg.sv
// Shared types for the effect frame sequencer: FSM encoding and effect codes.
package effect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [7:0] EFFECT_GRAY   = 8'h00;
    localparam logic [7:0] EFFECT_THRESH = 8'h01;

endpackage

// File: rtl/effect_frame_ctrl_if.sv
// Pixel stream bundle: upstream valid/ready, mux result, downstream valid/ready/last.
interface effect_frame_ctrl_if #(
    parameter int PIX_W = 24
) ();
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] eff_color;
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_pixel;
    logic             m_last;

    modport master (
        output s_valid, eff_color, m_ready,
        input  s_ready, m_valid, m_pixel, m_last
    );

    modport slave (
        input  s_valid, eff_color, m_ready,
        output s_ready, m_valid, m_pixel, m_last
    );
endinterface

// File: rtl/effect_frame_ctrl_pix_out_reg.sv
// One-deep valid/ready output register; flush drops a pending beat without emitting it.
module pix_out_reg #(
    parameter int PIX_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [PIX_W-1:0] pix_o,
    output logic             last_o
);
    logic             valid_q;
    logic             last_q;
    logic [PIX_W-1:0] pix_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            pix_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            last_q  <= last_i;
            pix_q   <= pix_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pix_o   = pix_q;
    assign last_o  = last_q;
endmodule

// File: rtl/effect_frame_ctrl.sv
// Frame sequencer for the effect mux: latches effect/length at frame start, counts beats.
// Optional EFFECT_FRAME_STATS_EN adds frame_cnt, a count of completed (non-aborted) frames.
module effect_frame_ctrl
    import effect_pkg::*;
#(
    parameter int CNT_W = 24,
    parameter int SEL_W = 8,
    parameter int PIX_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] cfg_select,
    input  logic [CNT_W-1:0] cfg_npix,
    input  logic             start,
    input  logic             abort,
    output logic [SEL_W-1:0] effect_sel,
    effect_frame_ctrl_if.slave px,
    output logic             busy,
    output logic             done
`ifdef EFFECT_FRAME_STATS_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] npix_q, npix_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             done_q, done_d;
    logic             flush;
    logic             last_beat;
    logic             accept;
    logic             s_ready_c;

    // An abort in the same cycle blocks the handshake so no beat slips into a dying frame.
    assign s_ready_c = (state_q == ST_RUN) && !abort && (!px.m_valid || px.m_ready);
    assign accept    = px.s_valid && s_ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            npix_q  <= '0;
            sel_q   <= SEL_W'(EFFECT_GRAY);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            npix_q  <= npix_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        npix_d    = npix_q;
        sel_d     = sel_q;
        done_d    = 1'b0;
        flush     = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (cfg_npix != '0) begin
                        state_d = ST_RUN;
                        npix_d  = cfg_npix;
                        sel_d   = cfg_select;
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    flush   = 1'b1;
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == npix_q - CNT_W'(1)) begin
                        last_beat = 1'b1;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    flush   = 1'b1;
                end else if (px.m_valid && px.m_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    pix_out_reg #(.PIX_W(PIX_W)) u_out (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .load_i  (accept),
        .pix_i   (px.eff_color),
        .last_i  (last_beat),
        .ready_i (px.m_ready),
        .valid_o (px.m_valid),
        .pix_o   (px.m_pixel),
        .last_o  (px.m_last)
    );

    assign px.s_ready = s_ready_c;
    assign effect_sel = sel_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = done_q;

`ifdef EFFECT_FRAME_STATS_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (done_d && !(abort && state_q != ST_IDLE)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_effect_frame_ctrl.sv
// Directed bench for effect_frame_ctrl; eff_color models the mux as {effect_sel, source index}.
module tb_effect_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_select;
    logic [23:0] cfg_npix;
    logic        start;
    logic        abort;
    logic [7:0]  effect_sel;
    logic        busy;
    logic        done;
    logic [15:0] src_pix;
`ifdef EFFECT_FRAME_STATS_EN
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    effect_frame_ctrl_if #(.PIX_W(24)) px ();
    assign px.eff_color = {effect_sel, src_pix};

    effect_frame_ctrl #(.CNT_W(24), .SEL_W(8), .PIX_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_select (cfg_select),
        .cfg_npix   (cfg_npix),
        .start      (start),
        .abort      (abort),
        .effect_sel (effect_sel),
        .px         (px),
        .busy       (busy),
        .done       (done)
`ifdef EFFECT_FRAME_STATS_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [23:0] n, input logic [7:0] sel);
        cfg_npix   = n;
        cfg_select = sel;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("start_busy", busy, 1);
        check("start_sel", effect_sel, sel);
    endtask

    // Streams source indices 0,1,2.. and scores every output handshake.
    task automatic stream(input int n, input logic [7:0] sel_exp, input bit stall,
                          input int stop_acc, input int chg_after, input logic [7:0] chg_val);
        int          acc = 0;
        int          out = 0;
        int          cyc = 0;
        bit          hold_v = 1'b0;
        logic [23:0] hold_pix = '0;
        px.s_valid = 1'b1;
        src_pix    = 16'd0;
        while (out < n && cyc < 200 && acc != stop_acc) begin
            px.m_ready = stall ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (hold_v) begin
                check("stall_valid", px.m_valid, 1);
                check("stall_pix", px.m_pixel, hold_pix);
            end
            hold_v   = px.m_valid && !px.m_ready;
            hold_pix = px.m_pixel;
            if (px.m_valid && px.m_ready) begin
                check("beat_pix", px.m_pixel, {sel_exp, out[15:0]});
                check("beat_last", px.m_last, (out == n - 1));
                check("beat_sel", effect_sel, sel_exp);
                out++;
            end
            if (px.s_valid && px.s_ready) acc++;
            tick();
            src_pix = acc[15:0];
            if (chg_after >= 0 && acc >= chg_after) cfg_select = chg_val;
            cyc++;
        end
        px.s_valid = 1'b0;
        px.m_ready = 1'b1;
        if (stop_acc < 0) check("beat_count", out, n);
        else check("acc_count", acc, stop_acc);
    endtask

    task automatic expect_done();
        check("done_pulse", done, 1);
        check("done_idle", busy, 0);
        tick();
        check("done_clear", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_select = 8'h00;
        cfg_npix   = 24'd0;
        src_pix    = 16'd0;
        px.s_valid = 1'b0;
        px.m_ready = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", effect_sel, 0);
        check("rst_mvalid", px.m_valid, 0);
        check("rst_mpixel", px.m_pixel, 0);
        check("rst_mlast", px.m_last, 0);
        check("rst_sready", px.s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // T1: basic 4-beat frame, grayscale
        start_frame(24'd4, 8'h00);
        stream(4, 8'h00, 1'b0, -1, -1, 8'h00);
        expect_done();

        // T2: cfg_select change mid-frame is ignored; next frame picks it up
        start_frame(24'd3, 8'h01);
        stream(3, 8'h01, 1'b0, -1, 1, 8'h00);
        expect_done();
        check("t2_cfg_now", cfg_select, 0);
        start_frame(24'd2, 8'h00);
        stream(2, 8'h00, 1'b0, -1, -1, 8'h00);
        expect_done();

        // T3: downstream backpressure
        start_frame(24'd8, 8'h01);
        stream(8, 8'h01, 1'b1, -1, -1, 8'h00);
        expect_done();

        // T4: abort after 5 accepts, then full restart
        start_frame(24'd16, 8'h01);
        stream(16, 8'h01, 1'b0, 5, -1, 8'h00);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_mvalid", px.m_valid, 0);
        check("abort_sready", px.s_ready, 0);
        check("abort_done", done, 1);
        tick();
        check("abort_done_clr", done, 0);
        start_frame(24'd16, 8'h01);
        stream(16, 8'h01, 1'b0, -1, -1, 8'h00);
        expect_done();

        // T5: zero-length frame, start while busy, abort+start in IDLE
        cfg_npix = 24'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("zero_busy", busy, 0);
        check("zero_done", done, 1);
        tick();
        check("zero_done_clr", done, 0);
        check("zero_busy2", busy, 0);

        start_frame(24'd4, 8'h01);
        cfg_select = 8'h02;
        cfg_npix   = 24'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_sel", effect_sel, 8'h01);
        stream(4, 8'h01, 1'b0, -1, -1, 8'h00);
        expect_done();

        cfg_npix = 24'd4;
        start    = 1'b1;
        abort    = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abst_busy", busy, 0);
        check("abst_done", done, 0);

        // T6: asynchronous reset between clock edges
        start_frame(24'd16, 8'h01);
        stream(16, 8'h01, 1'b0, 3, -1, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_sel", effect_sel, 0);
        check("arst_mvalid", px.m_valid, 0);
        check("arst_mpixel", px.m_pixel, 0);
        check("arst_mlast", px.m_last, 0);
        check("arst_done", done, 0);
        check("arst_sready", px.s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        start_frame(24'd2, 8'h01);
        stream(2, 8'h01, 1'b0, -1, -1, 8'h00);
        expect_done();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
